// File: rtl/sklansky_pkg.sv
// Shared types and helpers for the Sklansky prefix adder: level count,
// the prefix carry operator and the per-beat pipeline record.
package sklansky_pkg;

    localparam int MAX_W = 64;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int levels_of(input int width);
        return clog2(width);
    endfunction

    // Operands and result are packed as {G, P}; hi is the more significant span.
    function automatic logic [1:0] carry_op(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    // Vectors are sized for the widest build; narrower builds use the low bits.
    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             ci;
        logic [MAX_W-1:0] gg;
        logic [MAX_W-1:0] pp;
        logic [MAX_W-1:0] p;
    } beat_t;

endpackage

// File: rtl/sk_prefix_level.sv
// One combinational Sklansky level: each position with bit LEVEL set absorbs
// the group ending just below its aligned 2^LEVEL block.
module sk_prefix_level
    import sklansky_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_p
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pos
        if (((gi >> LEVEL) & 1) == 1) begin : g_combine
            localparam int J = ((gi >> LEVEL) << LEVEL) - 1;
            assign {o_g[gi], o_p[gi]} = carry_op({i_g[gi], i_p[gi]}, {i_g[J], i_p[J]});
        end else begin : g_pass
            assign o_g[gi] = i_g[gi];
            assign o_p[gi] = i_p[gi];
        end
    end

endmodule

// File: rtl/sklansky_pipe_adder.sv
// Valid/ready Sklansky prefix adder/subtractor with an optional register after
// every prefix level and a registered sum/carry/overflow output stage.
module sklansky_pipe_adder
    import sklansky_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int PIPELINED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int LEVELS = levels_of(WIDTH);

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic             w_ci_eff;
    beat_t            w_pre;
    beat_t            w_stage [LEVELS+1];
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;

    logic             r_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;

    // Gating with rst keeps out_valid low and in_ready high during the reset cycle.
    assign out_valid = r_valid & ~rst;
    assign w_adv     = out_ready | ~out_valid;
    assign in_ready  = w_adv;

    assign w_b_eff  = sub ? ~b : b;
    assign w_ci_eff = sub | ci;
    assign w_g      = a & w_b_eff;
    assign w_p      = a ^ w_b_eff;

    // Carry-in is folded into position 0 as a G-only term, so position 0 leaves with P=0.
    always_comb begin
        w_pre                 = '0;
        w_pre.valid           = in_valid;
        w_pre.sub             = sub;
        w_pre.ci              = w_ci_eff;
        w_pre.p[WIDTH-1:0]    = w_p;
        w_pre.gg[WIDTH-1:0]   = w_g;
        w_pre.pp[WIDTH-1:0]   = w_p;
        {w_pre.gg[0], w_pre.pp[0]} = carry_op({w_g[0], w_p[0]}, {w_ci_eff, 1'b0});
    end

    assign w_stage[0] = w_pre;

    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
        logic [WIDTH-1:0] w_g_out;
        logic [WIDTH-1:0] w_p_out;
        beat_t            w_next;

        sk_prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (gi)
        ) u_level (
            .i_g (w_stage[gi].gg[WIDTH-1:0]),
            .i_p (w_stage[gi].pp[WIDTH-1:0]),
            .o_g (w_g_out),
            .o_p (w_p_out)
        );

        always_comb begin
            w_next                 = w_stage[gi];
            w_next.gg[WIDTH-1:0]   = w_g_out;
            w_next.pp[WIDTH-1:0]   = w_p_out;
        end

        if (PIPELINED != 0) begin : g_reg
            beat_t r_beat;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_beat <= '0;
                end else if (w_adv) begin
                    r_beat <= w_next;
                end
            end
            assign w_stage[gi+1] = r_beat;
        end else begin : g_comb
            assign w_stage[gi+1] = w_next;
        end
    end

    // After the last level gg[i] is the carry out of bit i, carry-in included.
    assign w_carry = {w_stage[LEVELS].gg[WIDTH-2:0], w_stage[LEVELS].ci};
    assign w_sum   = w_stage[LEVELS].p[WIDTH-1:0] ^ w_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_adv) begin
            r_valid <= w_stage[LEVELS].valid;
            r_s     <= w_sum;
            r_co    <= w_stage[LEVELS].gg[WIDTH-1];
            r_ovf   <= w_stage[LEVELS].gg[WIDTH-1] ^ w_stage[LEVELS].gg[WIDTH-2];
        end
    end

    assign s   = r_s;
    assign co  = r_co;
    assign ovf = r_ovf;

    // Padding bits above WIDTH and fields not needed by the output stage end here.
    logic [LEVELS:0] w_unused_bits;
    for (genvar gi = 0; gi <= LEVELS; gi++) begin : g_sink
        assign w_unused_bits[gi] = ^w_stage[gi];
    end
    logic w_unused;
    assign w_unused = ^w_unused_bits;

endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Bench for sklansky_pipe_adder: a 16-bit pipelined instance checked by vector
// table and scoreboard, and a 64-bit unpipelined instance for the carry chain.
module tb_sklansky_pipe_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit, PIPELINED=1 instance
    logic        t_in_valid = 1'b0;
    logic        t_in_ready;
    logic [15:0] t_a = '0;
    logic [15:0] t_b = '0;
    logic        t_ci = 1'b0;
    logic        t_sub = 1'b0;
    logic        t_out_valid;
    logic        t_out_ready = 1'b1;
    logic [15:0] t_s;
    logic        t_co;
    logic        t_ovf;

    // 64-bit, PIPELINED=0 instance
    logic        u_in_valid = 1'b0;
    logic        u_in_ready;
    logic [63:0] u_a = '0;
    logic [63:0] u_b = '0;
    logic        u_ci = 1'b0;
    logic        u_sub = 1'b0;
    logic        u_out_valid;
    logic        u_out_ready = 1'b1;
    logic [63:0] u_s;
    logic        u_co;
    logic        u_ovf;

    sklansky_pipe_adder #(.WIDTH(16), .PIPELINED(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .a(t_a), .b(t_b), .ci(t_ci), .sub(t_sub),
        .out_valid(t_out_valid), .out_ready(t_out_ready),
        .s(t_s), .co(t_co), .ovf(t_ovf)
    );

    sklansky_pipe_adder #(.WIDTH(64), .PIPELINED(0)) dut64 (
        .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .a(u_a), .b(u_b), .ci(u_ci), .sub(u_sub),
        .out_valid(u_out_valid), .out_ready(u_out_ready),
        .s(u_s), .co(u_co), .ovf(u_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    logic rand_rdy = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired", name);
    endfunction

    // Reference: {ovf, co, s} from plain arithmetic on the operands.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic sb);
        logic [16:0] full;
        logic [15:0] r;
        logic        cout;
        logic        v;
        if (sb) begin
            full = {1'b0, x} - {1'b0, y};
            r    = full[15:0];
            cout = (x >= y);
            v    = (x[15] != y[15]) && (r[15] != x[15]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {16'd0, c};
            r    = full[15:0];
            cout = full[16];
            v    = (x[15] == y[15]) && (r[15] != x[15]);
        end
        return {v, cout, r};
    endfunction

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    logic [17:0] sb[$];
    logic        stall_prev = 1'b0;
    logic [17:0] prev_out = '0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("hold_stable", {45'd0, t_out_valid, t_ovf, t_co, t_s}, {45'd0, 1'b1, prev_out});
            if (t_out_valid && t_out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got s=%h with no beat outstanding", t_s);
                end else begin
                    logic [17:0] e;
                    e = sb.pop_front();
                    n_out++;
                    check($sformatf("sb_beat%0d", n_out), {46'd0, t_ovf, t_co, t_s}, {46'd0, e});
                end
            end
            if (t_in_valid && t_in_ready)
                sb.push_back(model16(t_a, t_b, t_ci, t_sub));
            stall_prev = t_out_valid && !t_out_ready;
            prev_out   = {t_ovf, t_co, t_s};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) t_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic sb_i, output int waits);
        t_a = x; t_b = y; t_ci = c; t_sub = sb_i; t_in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (t_in_ready && !rst) break;
            waits++;
            if (waits > 300) begin
                fail_timeout("send_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        t_in_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (t_out_valid) break;
            if (lat >= 30) begin
                fail_timeout("wait_result");
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t vec [8];

    initial begin
        int w;
        int lat;
        int base;
        int cnt;
        logic [15:0] held_s;

        vec[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vec[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vec[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vec[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vec[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vec[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vec[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vec[7] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, t_out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, t_in_ready}, 64'd1);
        check("rst_s_co_ovf", {46'd0, t_ovf, t_co, t_s}, 64'd0);
        check("rst_out_valid64", {63'd0, u_out_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table: exact latency and hand-computed results
        for (int i = 0; i < 8; i++) begin
            send(vec[i].a, vec[i].b, vec[i].ci, vec[i].sub, w);
            if (i == 0) check("first_accept_wait", 64'(w), 64'd0);
            wait_result(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
            check($sformatf("vec%0d_s", i), {48'd0, t_s}, {48'd0, vec[i].s});
            check($sformatf("vec%0d_co_ovf", i), {62'd0, t_co, t_ovf}, {62'd0, vec[i].co, vec[i].ovf});
            @(posedge clk);
            #1;
        end

        // Random stream with random back-pressure
        rand_rdy = 1'b1;
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
        cnt = 0;
        while (sb.size() != 0 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (sb.size() != 0) fail_timeout("stream_drain");
        check("stream_count", 64'(n_out - base), 64'd100);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        t_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Fill the pipeline, stall 10 cycles, then release
        t_out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(16'h1000 + 16'(i), 16'h0100, 1'b0, 1'(i & 1), w);
        @(negedge clk);
        held_s = t_s;
        check("fill_out_valid", {63'd0, t_out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_in_ready", i), {63'd0, t_in_ready}, 64'd0);
            check($sformatf("stall%0d_s", i), {48'd0, t_s}, {48'd0, held_s});
        end
        @(posedge clk);
        #1;
        t_out_ready = 1'b1;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!t_out_valid) break;
            cnt++;
            if (cnt > 20) begin
                fail_timeout("release_drain");
                break;
            end
        end
        check("release_consecutive", 64'(cnt), 64'd5);

        // Reset with three beats in flight; a beat offered during reset is dropped
        for (int i = 0; i < 3; i++)
            send(16'h2222, 16'(i), 1'b0, 1'b0, w);
        rst = 1'b1;
        t_a = 16'hABCD; t_b = 16'h1111; t_ci = 1'b0; t_sub = 1'b0; t_in_valid = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {63'd0, t_out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, t_in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        t_in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("postrst_s", {48'd0, t_s}, 64'd0);
            check($sformatf("postrst%0d_out_valid", i), {63'd0, t_out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        send(16'h00F0, 16'h000F, 1'b1, 1'b0, w);
        check("postrst_accept_wait", 64'(w), 64'd0);
        wait_result(lat);
        check("postrst_latency", 64'(lat), 64'd5);
        check("postrst_result", {48'd0, t_s}, 64'h0100);
        @(posedge clk);
        #1;

        // 64-bit unpipelined carry chain
        for (int k = 1; k < 64; k++) begin
            u_a = (64'd1 << k) - 64'd1;
            u_b = 64'd1;
            u_in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("chain%0d_pre_valid", k), {63'd0, u_out_valid}, 64'd0);
            @(posedge clk);
            #1;
            u_in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("chain%0d_valid", k), {63'd0, u_out_valid}, 64'd1);
            check($sformatf("chain%0d_s", k), u_s, 64'd1 << k);
            check($sformatf("chain%0d_co_ovf", k), {62'd0, u_co, u_ovf}, {62'd0, 1'b0, (k == 63)});
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d of %0d checks)", n_errors, n_checks);
        $fatal(1);
    end

endmodule
